ua_pipe: RTL and testbench
==========================

# ua_pipe

Parametrised, pipelined arithmetic unit for the Tomasulo datapath. It is the next generation of the fixed three-cycle, single-occupancy unit. Each cycle it accepts one operation from its reservation station, carries the station's tag through a configurable-depth pipeline, and presents `{tag, result}` to the CDB arbiter. The result is held until the arbiter grants the bus. Up to LAT operations can be in flight at once.

## Interface
Parameters:
- DATA_W, 16: operand and result width.
- TAG_W, 3: reservation-station tag width.
- LAT, 3: issue-to-result latency in cycles with no stall; legal range 1..8.

Ports:
- CLK  in  1: clock, rising edge.
- CLR_N  in  1: reset, synchronous, active-low.
- start  in  1: issue valid; the operation is accepted when start=1 and busy=0.
- ID_in  in  TAG_W: tag of the issuing station.
- Dado1, Dado2  in  DATA_W: operands.
- op  in  3: opcode, values from ua_pkg.
- cdb_ack  in  1: CDB grant; meaningful only while confirmacao=1.
- busy  out  1: unit cannot accept an operation this cycle. Combinational.
- confirmacao  out  1: Resultado is valid.
- Resultado  out  TAG_W+DATA_W: {tag, data}, tag in the MSBs.
- ovf  out  1: present only with UA_OVF_EN.

## Operation
- Stage slots 0..LAT-1. Each slot holds a valid bit, tag, data and ovf. Slot LAT-1 drives the outputs.
- Opcodes and results, computed combinationally at issue and captured into slot 0:
  - 001 ADD: Dado1+Dado2
  - 010 SUB: Dado1−Dado2
  - 011 LD address: Dado1+Dado2
  - 100 ST address: Dado1+Dado2
- All results are modulo 2^DATA_W; no carry-out is kept.
- Illegal opcodes (000, 101–111): the entry still flows through the pipeline with data=0 and ovf=0, so the issuing station is freed.
- Advance rule: the output slot can load when it is empty or cdb_ack=1. Slot k can load when it is empty or slot k+1 can load. The rule ripples back from the output.
- busy = NOT can_load[0]. This is a combinational path from cdb_ack to busy.
- An accepted issue writes slot 0. A slot that moves forward without a new entry arriving behind it clears its valid bit.
- confirmacao = valid of slot LAT-1. Resultado and ovf stay stable while confirmacao=1 and cdb_ack=0.
- Retire: confirmacao=1 and cdb_ack=1 in the same cycle. On that edge the next entry (if any) moves into the output slot, so back-to-back results are possible.
- cdb_ack while confirmacao=0 is ignored.

## Timing
- Reset (CLR_N=0 at an edge): all valid bits clear; Resultado=0, confirmacao=0, ovf=0. busy=0 in the cycle after reset.
- start is ignored in any cycle where CLR_N=0. Reset mid-operation discards all in-flight entries, with no partial retire.
- Latency: issue at edge N gives confirmacao=1 after edge N+LAT-1, i.e. visible for the first time in cycle N+LAT, with no stall.
- Throughput: 1 op/cycle while cdb_ack is held high.
- Stalled with all slots full: busy=1. A cdb_ack in that cycle deasserts busy in the same cycle, and an issue plus a retire then happen on the same edge.
- LAT=1: slot 0 is the output slot. busy = confirmacao AND NOT cdb_ack.

## Configuration
- UA_OVF_EN defined:
  - ovf port exists.
  - ovf=1 for signed two's-complement overflow of ADD/SUB.
  - ovf=0 for LD/ST and illegal opcodes.
  - ovf is carried with its entry and held with Resultado.
- UA_OVF_EN undefined: ovf port and its storage are absent; all other behaviour is identical.

## Structure
- ua_pkg holds:
  - opcode localparams: OP_ADD=3'b001, OP_SUB=3'b010, OP_LD=3'b011, OP_ST=3'b100
  - a typedef for the stage entry {valid, tag, data, ovf}
- Sub-module ua_alu: the combinational op decode, arithmetic and ovf computation, instantiated once in front of slot 0.
- The slot chain is a generate loop in ua_pipe.

## Test plan
- Reset then single ADD: LAT=3, tag 5, 0x0003+0x0004, cdb_ack=1 → confirmacao in cycle 3 after issue with Resultado={5,0x0007}, busy never 1.
- SUB wrap: 0x0000−0x0001 → data 0xFFFF. With UA_OVF_EN: 0x7FFF+0x0001 → data 0x8000, ovf=1.
- Back-to-back stream: 6 issues on consecutive cycles, cdb_ack=1 → 6 consecutive confirmacao cycles with tags in issue order, busy=0 throughout.
- Backpressure: cdb_ack=0 with 4 issues attempted at LAT=3 → first 3 accepted, busy=1 on the 4th, Resultado stable. Raise cdb_ack → busy drops the same cycle, the 4th issue is accepted, all retire in order.
- Illegal opcode 3'b110, tag 2 → Resultado={2,0x0000}, confirmacao asserted normally.
- Reset mid-flight: 2 ops in flight, CLR_N=0 for one edge → confirmacao=0 and nothing retires. A fresh ADD afterwards completes with the nominal latency.

Source files
------------

// File: rtl/ua_pkg.sv
// Shared opcodes and pipeline entry layout for the ua_pipe arithmetic unit.
// Optional feature macro: UA_OVF_EN adds the per-entry signed-overflow flag.
package ua_pkg;

  localparam int unsigned UA_DATA_W = 16;
  localparam int unsigned UA_TAG_W  = 3;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_LD  = 3'b011;
  localparam logic [2:0] OP_ST  = 3'b100;

  // One pipeline slot; payload widths track the package defaults of ua_pipe.
  typedef struct packed {
    logic                 valid;
    logic [UA_TAG_W-1:0]  tag;
    logic [UA_DATA_W-1:0] data;
`ifdef UA_OVF_EN
    logic                 ovf;
`endif
  } ua_entry_t;

endpackage

// File: rtl/ua_alu.sv
// Combinational opcode decode and arithmetic feeding slot 0 of ua_pipe.
// With UA_OVF_EN defined it also flags signed overflow of ADD/SUB.
module ua_alu
  import ua_pkg::*;
#(
  parameter int unsigned DATA_W = UA_DATA_W
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res_c
`ifdef UA_OVF_EN
  ,
  output logic              ovf_c
`endif
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  // Illegal opcodes still produce an entry, with zero data.
  always_comb begin
    res_c = '0;
    case (op)
      OP_ADD, OP_LD, OP_ST: res_c = sum;
      OP_SUB:               res_c = diff;
      default:              res_c = '0;
    endcase
  end

`ifdef UA_OVF_EN
  always_comb begin
    ovf_c = 1'b0;
    case (op)
      OP_ADD:  ovf_c = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      OP_SUB:  ovf_c = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      default: ovf_c = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/ua_pipe.sv
// Pipelined Tomasulo arithmetic unit: LAT slots (1..8), results held for the CDB grant.
// Optional feature macro: UA_OVF_EN exposes the ovf port and its per-slot storage.
module ua_pipe
  import ua_pkg::*;
#(
  parameter int unsigned DATA_W = UA_DATA_W,
  parameter int unsigned TAG_W  = UA_TAG_W,
  parameter int unsigned LAT    = 3
) (
  input  logic                    CLK,
  input  logic                    CLR_N,
  input  logic                    start,
  input  logic [TAG_W-1:0]        ID_in,
  input  logic [DATA_W-1:0]       Dado1,
  input  logic [DATA_W-1:0]       Dado2,
  input  logic [2:0]              op,
  input  logic                    cdb_ack,
  output logic                    busy,
  output logic                    confirmacao,
  output logic [TAG_W+DATA_W-1:0] Resultado
`ifdef UA_OVF_EN
  ,
  output logic                    ovf
`endif
);

  logic [DATA_W-1:0] alu_res_c;
`ifdef UA_OVF_EN
  logic              alu_ovf_c;
`endif
  logic [LAT-1:0]    can_load;
  ua_entry_t         issue_entry;
  ua_entry_t         stage_q [LAT];

  ua_alu #(.DATA_W(DATA_W)) u_alu (
    .op    (op),
    .a     (Dado1),
    .b     (Dado2),
    .res_c (alu_res_c)
`ifdef UA_OVF_EN
    ,
    .ovf_c (alu_ovf_c)
`endif
  );

  // Advance enables ripple back from the output slot, so a grant frees slot 0 this cycle.
  always_comb begin
    can_load          = '0;
    can_load[LAT-1]   = !stage_q[LAT-1].valid || cdb_ack;
    for (int k = int'(LAT) - 2; k >= 0; k--) begin
      can_load[k] = !stage_q[k].valid || can_load[k+1];
    end
  end

  assign busy = !can_load[0];

  always_comb begin
    issue_entry       = '0;
    issue_entry.valid = start && can_load[0];
    issue_entry.tag   = ID_in;
    issue_entry.data  = alu_res_c;
`ifdef UA_OVF_EN
    issue_entry.ovf   = alu_ovf_c;
`endif
  end

  for (genvar k = 0; k < int'(LAT); k++) begin : g_slot
    ua_entry_t slot_q;
    ua_entry_t slot_d;
    ua_entry_t src;

    if (k == 0) begin : g_head
      assign src = issue_entry;
    end else begin : g_body
      assign src = stage_q[k-1];
    end

    // A loading slot takes whatever sits behind it, including an empty entry.
    always_comb begin
      slot_d = slot_q;
      if (can_load[k]) begin
        slot_d = src;
      end
    end

    always_ff @(posedge CLK) begin
      if (!CLR_N) begin
        slot_q <= '0;
      end else begin
        slot_q <= slot_d;
      end
    end

    assign stage_q[k] = slot_q;
  end

  assign confirmacao = stage_q[LAT-1].valid;
  assign Resultado   = {stage_q[LAT-1].tag, stage_q[LAT-1].data};
`ifdef UA_OVF_EN
  assign ovf         = stage_q[LAT-1].ovf;
`endif

endmodule

// File: tb/tb_ua_pipe.sv
// Directed self-checking bench for ua_pipe at LAT=3, DATA_W=16, TAG_W=3.
// Overflow checks are compiled in when UA_OVF_EN is defined.
module tb_ua_pipe;

  localparam logic [2:0] T_ADD = 3'b001;
  localparam logic [2:0] T_SUB = 3'b010;
  localparam logic [2:0] T_ILL = 3'b110;

  logic        CLK = 1'b0;
  logic        CLR_N;
  logic        start;
  logic [2:0]  ID_in;
  logic [15:0] Dado1;
  logic [15:0] Dado2;
  logic [2:0]  op;
  logic        cdb_ack;
  logic        busy;
  logic        confirmacao;
  logic [18:0] Resultado;
`ifdef UA_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;

  ua_pipe #(.DATA_W(16), .TAG_W(3), .LAT(3)) dut (
    .CLK         (CLK),
    .CLR_N       (CLR_N),
    .start       (start),
    .ID_in       (ID_in),
    .Dado1       (Dado1),
    .Dado2       (Dado2),
    .op          (op),
    .cdb_ack     (cdb_ack),
    .busy        (busy),
    .confirmacao (confirmacao),
    .Resultado   (Resultado)
`ifdef UA_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] t, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] o);
    start = 1'b1;
    ID_in = t;
    Dado1 = a;
    Dado2 = b;
    op    = o;
  endtask

  // Issue one op with the bus granted and check the three-cycle result window.
  task automatic run_single(input string name, input logic [2:0] t, input logic [15:0] a,
                            input logic [15:0] b, input logic [2:0] o,
                            input logic [31:0] exp_res);
    @(negedge CLK);
    issue(t, a, b, o);
    cdb_ack = 1'b1;
    #1 chk({name, "_busy"}, 32'(busy), 32'd0);
    @(negedge CLK);
    start = 1'b0;
    #1 chk({name, "_conf_c1"}, 32'(confirmacao), 32'd0);
    @(negedge CLK);
    #1 chk({name, "_conf_c2"}, 32'(confirmacao), 32'd0);
    @(negedge CLK);
    #1 chk({name, "_conf_c3"}, 32'(confirmacao), 32'd1);
    chk({name, "_res"}, 32'(Resultado), exp_res);
    @(negedge CLK);
    #1 chk({name, "_retired"}, 32'(confirmacao), 32'd0);
  endtask

  initial begin
    CLR_N   = 1'b0;
    start   = 1'b0;
    ID_in   = '0;
    Dado1   = '0;
    Dado2   = '0;
    op      = '0;
    cdb_ack = 1'b0;

    // Reset
    @(negedge CLK);
    @(negedge CLK);
    CLR_N = 1'b1;
    #1 chk("rst_conf", 32'(confirmacao), 32'd0);
    chk("rst_res", 32'(Resultado), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef UA_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif

    // Single ADD and SUB wrap
    run_single("add", 3'd5, 16'h0003, 16'h0004, T_ADD, 32'h0005_0007);
    run_single("sub_wrap", 3'd1, 16'h0000, 16'h0001, T_SUB, 32'h0001_FFFF);
`ifdef UA_OVF_EN
    @(negedge CLK);
    issue(3'd3, 16'h7FFF, 16'h0001, T_ADD);
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #1 chk("ovf_res", 32'(Resultado), 32'h0003_8000);
    chk("ovf_flag", 32'(ovf), 32'd1);
    @(negedge CLK);
    issue(3'd4, 16'h0000, 16'h0001, T_SUB);
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #1 chk("nov_res", 32'(Resultado), 32'h0004_FFFF);
    chk("nov_flag", 32'(ovf), 32'd0);
`endif

    // Back-to-back stream of 6 with cdb_ack held high
    cdb_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (i < 6) issue(3'(i), 16'(4096 + i), 16'(i), T_ADD);
      else start = 1'b0;
      #1 chk($sformatf("stream_busy%0d", i), 32'(busy), 32'd0);
      if (i >= 3 && i < 9) begin
        chk($sformatf("stream_conf%0d", i), 32'(confirmacao), 32'd1);
        chk($sformatf("stream_res%0d", i),
            32'(Resultado), (32'(i - 3) << 16) | (32'h1000 + 32'(2 * (i - 3))));
      end else begin
        chk($sformatf("stream_idle%0d", i), 32'(confirmacao), 32'd0);
      end
    end

    // Backpressure: 4 issues attempted with cdb_ack low
    cdb_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      issue(3'(i + 1), 16'(i + 1), 16'h0010, T_ADD);
      #1 chk($sformatf("bp_busy%0d", i), 32'(busy), 32'd0);
    end
    @(negedge CLK);
    issue(3'd4, 16'h0004, 16'h0010, T_ADD);
    #1 chk("bp_full_busy", 32'(busy), 32'd1);
    chk("bp_full_conf", 32'(confirmacao), 32'd1);
    chk("bp_full_res", 32'(Resultado), 32'h0001_0011);
    @(negedge CLK);
    #1 chk("bp_hold_busy", 32'(busy), 32'd1);
    chk("bp_hold_res", 32'(Resultado), 32'h0001_0011);
    @(negedge CLK);
    cdb_ack = 1'b1;
    #1 chk("bp_ack_busy", 32'(busy), 32'd0);
    chk("bp_ack_res", 32'(Resultado), 32'h0001_0011);
    for (int i = 2; i <= 4; i++) begin
      @(negedge CLK);
      start = 1'b0;
      #1 chk($sformatf("bp_drain_conf%0d", i), 32'(confirmacao), 32'd1);
      chk($sformatf("bp_drain_res%0d", i), 32'(Resultado), (32'(i) << 16) | 32'(i + 16));
    end
    @(negedge CLK);
    #1 chk("bp_empty", 32'(confirmacao), 32'd0);

    // Illegal opcode still completes with zero data
    run_single("illegal", 3'd2, 16'h1234, 16'h0001, T_ILL, 32'h0002_0000);

    // Reset mid-flight discards entries; start during reset is ignored
    @(negedge CLK);
    issue(3'd6, 16'h0001, 16'h0001, T_ADD);
    @(negedge CLK);
    issue(3'd7, 16'h0002, 16'h0002, T_ADD);
    @(negedge CLK);
    issue(3'd5, 16'h0003, 16'h0003, T_ADD);
    CLR_N = 1'b0;
    @(negedge CLK);
    CLR_N = 1'b1;
    start = 1'b0;
    #1 chk("mid_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mid_rst_conf%0d", i), 32'(confirmacao), 32'd0);
      @(negedge CLK);
      #1;
    end
    run_single("post_rst", 3'd3, 16'h0020, 16'h0002, T_ADD, 32'h0003_0022);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
